opmem_sp_gen: RTL and testbench

Parametrised single-port synchronous RAM, the successor to the fixed 8x8 operand memory. Width, depth, read pipelining and write mode are generic. Adds per-byte write enables, a read-data valid flag that tracks the configured latency, and out-of-range address protection. Sits beside the operand datapath and is inferred from RTL, not built from a vendor primitive.

---
 rtl/opmem_sp_gen_pkg.sv | 31 +++
 rtl/opmem_sp_gen_if.sv | 25 ++
 rtl/opmem_sp_gen_outreg.sv | 48 ++++
 rtl/opmem_sp_gen.sv | 126 ++++++++++++
 tb/tb_opmem_sp_gen.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opmem_sp_gen_pkg.sv
// Shared constants and helpers for the parametrised operand memory (opmem_sp_gen).
// Optional byte parity is enabled by defining OPMEM_PARITY_EN.
package opmem_pkg;

  localparam int WM_NORMAL            = 0;
  localparam int WM_WRITE_THROUGH     = 1;
  localparam int WM_READ_BEFORE_WRITE = 2;
  localparam int RM_BYPASS            = 0;
  localparam int RM_PIPELINE          = 1;

  // Helpers work on the widest supported word; callers cast to their own DATA_W.
  localparam int MAX_DATA_W = 512;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0]   old_w,
    input logic [MAX_DATA_W-1:0]   new_w,
    input logic [MAX_DATA_W/8-1:0] be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_DATA_W/8; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/opmem_sp_gen_if.sv
// Access bus of the operand memory: request fields from the master, read data back from the slave.
interface opmem_sp_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                ce;
  logic                oce;
  logic                wre;
  logic [DATA_W/8-1:0] be;
  logic [ADDR_W-1:0]   ad;
  logic [DATA_W-1:0]   din;
  logic [DATA_W-1:0]   dout;
  logic                dout_vld;
  logic                parity_err;

  modport master (
    output ce, oce, wre, be, ad, din,
    input  dout, dout_vld, parity_err
  );

  modport slave (
    input  ce, oce, wre, be, ad, din,
    output dout, dout_vld, parity_err
  );
endinterface

// File: rtl/opmem_sp_gen_outreg.sv
// Enable-gated output register (data, valid, parity error) with async reset.
// Data holds while disabled; valid and parity error drop so no stale pulse repeats.
module opmem_outreg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  input  logic              in_perr,
  output logic [DATA_W-1:0] q_data,
  output logic              q_vld,
  output logic              q_perr
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              vld_d, vld_q;
  logic              perr_d, perr_q;

  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    perr_d = 1'b0;
    if (en) begin
      data_d = in_data;
      vld_d  = in_vld;
      perr_d = in_perr & in_vld;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      perr_q <= perr_d;
    end
  end

  assign q_data = data_q;
  assign q_vld  = vld_q;
  assign q_perr = perr_q;

endmodule

// File: rtl/opmem_sp_gen.sv
// Parametrised single-port operand RAM with byte enables, latency-tracking valid and
// out-of-range protection. Define OPMEM_PARITY_EN to store and check per-byte even parity.
module opmem_sp_gen
  import opmem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 8,
  parameter int READ_MODE  = 0,
  parameter int WRITE_MODE = 0
) (
  input  logic           clk,
  input  logic           reset,
  opmem_sp_gen_if.slave  bus
);

  localparam int NB = DATA_W / 8;

  if (DATA_W % 8 != 0)       begin : g_chk_w  $error("DATA_W must be a multiple of 8"); end
  if (DATA_W > MAX_DATA_W)   begin : g_chk_mx $error("DATA_W exceeds MAX_DATA_W"); end
  if (DEPTH > 2**ADDR_W)     begin : g_chk_d  $error("DEPTH must not exceed 2**ADDR_W"); end
  if (WRITE_MODE > 2)        begin : g_chk_wm $error("WRITE_MODE must be 0, 1 or 2"); end

  // Rows at or above DEPTH are never written nor observed, so they trim away.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word_d;
  logic              rd_perr;

  always_comb begin
    in_range  = (32'(bus.ad) < 32'(DEPTH));
    rd_word   = in_range ? mem_q[bus.ad] : '0;
    wr_word_d = DATA_W'(byte_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(bus.din),
                                   (MAX_DATA_W/8)'(bus.be)));
    wr_en     = bus.ce & bus.wre & in_range;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[bus.ad] <= wr_word_d;
  end

`ifdef OPMEM_PARITY_EN
  logic [NB-1:0] par_q [2**ADDR_W];
  logic [NB-1:0] wr_par_d;
  logic [NB-1:0] rd_par_calc;

  // Untouched bytes keep their stored parity so a latent error is not masked by a write.
  always_comb begin
    wr_par_d    = par_q[bus.ad];
    rd_par_calc = '0;
    for (int i = 0; i < NB; i++) begin
      if (bus.be[i]) wr_par_d[i] = even_parity(bus.din[8*i +: 8]);
      rd_par_calc[i] = even_parity(rd_word[8*i +: 8]);
    end
    rd_perr = in_range & (|(par_q[bus.ad] ^ rd_par_calc));
  end

  always_ff @(posedge clk) begin
    if (wr_en) par_q[bus.ad] <= wr_par_d;
  end
`else
  assign rd_perr = 1'b0;
`endif

  // Stage 1: access result
  logic [DATA_W-1:0] s1_data_d, s1_data_q;
  logic              s1_vld_d, s1_vld_q;
  logic              s1_perr_d, s1_perr_q;

  always_comb begin
    s1_data_d = s1_data_q;
    s1_vld_d  = 1'b0;
    s1_perr_d = 1'b0;
    if (bus.ce) begin
      if (!bus.wre) begin
        s1_data_d = rd_word;
        s1_vld_d  = 1'b1;
        s1_perr_d = rd_perr;
      end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
        s1_data_d = in_range ? wr_word_d : '0;
        s1_vld_d  = 1'b1;
      end else if (WRITE_MODE == WM_READ_BEFORE_WRITE) begin
        s1_data_d = rd_word;
        s1_vld_d  = 1'b1;
        s1_perr_d = rd_perr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_perr_q <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_vld_q  <= s1_vld_d;
      s1_perr_q <= s1_perr_d;
    end
  end

  // Stage 2: optional output register
  if (READ_MODE == RM_PIPELINE) begin : g_outreg
    opmem_outreg #(.DATA_W(DATA_W)) u_outreg (
      .clk     (clk),
      .reset   (reset),
      .en      (bus.oce),
      .in_data (s1_data_q),
      .in_vld  (s1_vld_q),
      .in_perr (s1_perr_q),
      .q_data  (bus.dout),
      .q_vld   (bus.dout_vld),
      .q_perr  (bus.parity_err)
    );
  end else begin : g_bypass
    logic unused_oce;
    assign unused_oce     = bus.oce;
    assign bus.dout       = s1_data_q;
    assign bus.dout_vld   = s1_vld_q;
    assign bus.parity_err = s1_perr_q & s1_vld_q;
  end

endmodule

// File: tb/tb_opmem_sp_gen.sv
// Bench for opmem_sp_gen: four configurations share one stimulus stream and are
// checked against directed constants and a word-level reference model.
module tb_opmem_sp_gen;

  logic        clk;
  logic        reset;
  logic        ce, oce, wre;
  logic [1:0]  be;
  logic [2:0]  ad;
  logic [15:0] din;

  logic [15:0] dout_a [4];
  logic        vld_a  [4];
  logic        perr_a [4];

  int errors;
  int checks;

  // Reference model state, one slot per instance
  logic [15:0] mem_m [4][8];
  logic [15:0] s1_w  [4];
  logic        s1_v  [4];
  logic [15:0] out_w [4];
  logic        out_v [4];

  opmem_sp_gen_if #(.DATA_W(16), .ADDR_W(3)) bus_a [4] ();

  // Instance 0..2: bypass read, WRITE_MODE 0/1/2, DEPTH 8. Instance 3: pipelined, DEPTH 6.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus_a[g].ce  = ce;
    assign bus_a[g].oce = oce;
    assign bus_a[g].wre = wre;
    assign bus_a[g].be  = be;
    assign bus_a[g].ad  = ad;
    assign bus_a[g].din = din;
    assign dout_a[g] = bus_a[g].dout;
    assign vld_a[g]  = bus_a[g].dout_vld;
    assign perr_a[g] = bus_a[g].parity_err;

    opmem_sp_gen #(
      .DATA_W     (16),
      .ADDR_W     (3),
      .DEPTH      ((g == 3) ? 6 : 8),
      .READ_MODE  ((g == 3) ? 1 : 0),
      .WRITE_MODE ((g == 3) ? 0 : g)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rm_of(int d);    return (d == 3) ? 1 : 0; endfunction
  function automatic int wm_of(int d);    return (d == 3) ? 0 : d; endfunction
  function automatic int depth_of(int d); return (d == 3) ? 6 : 8; endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      s1_w[d] = 16'h0; s1_v[d] = 1'b0; out_w[d] = 16'h0; out_v[d] = 1'b0;
    end
  endtask

  // Apply one clock edge of the access rules to every instance.
  task automatic model_step();
    for (int d = 0; d < 4; d++) begin
      logic        inr, av;
      logic [15:0] old_w, new_w, aw;
      inr   = (int'(ad) < depth_of(d));
      old_w = inr ? mem_m[d][ad] : 16'h0;
      for (int i = 0; i < 2; i++) new_w[8*i +: 8] = be[i] ? din[8*i +: 8] : old_w[8*i +: 8];
      av = 1'b0;
      aw = 16'h0;
      if (ce) begin
        if (!wre) begin
          av = 1'b1; aw = old_w;
        end else begin
          if (wm_of(d) == 1) begin av = 1'b1; aw = inr ? new_w : 16'h0; end
          if (wm_of(d) == 2) begin av = 1'b1; aw = old_w; end
          if (inr) mem_m[d][ad] = new_w;
        end
      end
      if (rm_of(d) == 1) begin
        if (oce) begin out_w[d] = s1_w[d]; out_v[d] = s1_v[d]; end
        else out_v[d] = 1'b0;
      end
      s1_v[d] = av;
      if (av) s1_w[d] = aw;
      if (rm_of(d) == 0) begin out_w[d] = s1_w[d]; out_v[d] = s1_v[d]; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_op(input logic c, input logic w, input logic [2:0] a,
                        input logic [15:0] d, input logic [1:0] b);
    ce = c; wre = w; ad = a; din = d; be = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    oce = 1'b1;
    model_reset();
    #3;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dout_a[d] !== 16'h0 || vld_a[d] !== 1'b0 || perr_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got dout=%h vld=%b perr=%b, want 0000/0/0",
                 d, dout_a[d], vld_a[d], perr_a[d]);
      end
    end
    @(posedge clk); #2 reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      set_op(1'b1, 1'b1, 3'(a), 16'hC000 | (16'(a) * 16'h0101), 2'b11);
      tick();
    end
    set_op(1'b1, 1'b0, 3'd5, 16'h0, 2'b00);
    tick();
    checks++;
    if (dout_a[0] !== 16'hC505 || vld_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: got %h/%b, want C505/1", dout_a[0], vld_a[0]);
    end
    // Assert reset mid-cycle while a read is in flight
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dout_a[d] !== 16'h0 || vld_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset[%0d]: got %h/%b, want 0000/0", d, dout_a[d], vld_a[d]);
      end
    end
    model_reset();
    ce = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    set_op(1'b1, 1'b0, 3'd5, 16'h0, 2'b00);
    tick();
    checks++;
    if (dout_a[0] !== 16'hC505 || vld_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL array_kept: got %h/%b, want C505/1", dout_a[0], vld_a[0]);
    end
  endtask

  task automatic test_byte_enables();
    set_op(1'b1, 1'b1, 3'd3, 16'hAAAA, 2'b11); tick();
    set_op(1'b1, 1'b1, 3'd3, 16'h5555, 2'b01); tick();
    set_op(1'b1, 1'b0, 3'd3, 16'h0,    2'b00); tick();
    checks++;
    if (dout_a[0] !== 16'hAA55 || vld_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL byte_en_read: got %h/%b, want AA55/1", dout_a[0], vld_a[0]);
    end
    set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00); tick();
    checks++;
    if (vld_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL vld_pulse: got vld=%b, want 0", vld_a[0]);
    end
    checks++;
    if (dout_a[3] !== 16'hAA55 || vld_a[3] !== 1'b1) begin
      errors++;
      $display("FAIL pipe_latency: got %h/%b, want AA55/1", dout_a[3], vld_a[3]);
    end
  endtask

  task automatic test_write_modes();
    set_op(1'b1, 1'b1, 3'd2, 16'h1234, 2'b11); tick();
    set_op(1'b1, 1'b1, 3'd2, 16'hBEEF, 2'b11); tick();
    checks++;
    if (dout_a[0] !== 16'hAA55 || vld_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL wm_normal: got %h/%b, want AA55/0", dout_a[0], vld_a[0]);
    end
    checks++;
    if (dout_a[1] !== 16'hBEEF || vld_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL wm_write_through: got %h/%b, want BEEF/1", dout_a[1], vld_a[1]);
    end
    checks++;
    if (dout_a[2] !== 16'h1234 || vld_a[2] !== 1'b1) begin
      errors++;
      $display("FAIL wm_read_before_write: got %h/%b, want 1234/1", dout_a[2], vld_a[2]);
    end
    set_op(1'b1, 1'b0, 3'd2, 16'h0, 2'b00); tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dout_a[d] !== 16'hBEEF || vld_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL read_after_write[%0d]: got %h/%b, want BEEF/1", d, dout_a[d], vld_a[d]);
      end
    end
  endtask

  task automatic test_read_pipeline();
    logic [15:0] want [3];
    want = '{16'hC000, 16'hC101, 16'hBEEF};
    oce = 1'b1;
    set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_op(1'b1, 1'b0, 3'(k), 16'h0, 2'b00);
      else       set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
      tick();
      if (k >= 1) begin
        checks++;
        if (dout_a[3] !== want[k-1] || vld_a[3] !== 1'b1) begin
          errors++;
          $display("FAIL stream[%0d]: got %h/%b, want %h/1", k-1, dout_a[3], vld_a[3], want[k-1]);
        end
      end
    end
    set_op(1'b1, 1'b0, 3'd1, 16'h0, 2'b00); tick();
    oce = 1'b0;
    set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00); tick();
    checks++;
    if (dout_a[3] !== 16'hBEEF || vld_a[3] !== 1'b0) begin
      errors++;
      $display("FAIL oce_hold: got %h/%b, want BEEF/0", dout_a[3], vld_a[3]);
    end
    oce = 1'b1;
  endtask

  task automatic test_out_of_range();
    logic [15:0] want [6];
    want = '{16'hC000, 16'hC101, 16'hBEEF, 16'hAA55, 16'hC404, 16'hC505};
    oce = 1'b1;
    set_op(1'b1, 1'b1, 3'd7, 16'hFFFF, 2'b11); tick();
    set_op(1'b1, 1'b0, 3'd7, 16'h0,    2'b00); tick();
    checks++;
    if (dout_a[0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL in_range_ad7: got %h, want FFFF", dout_a[0]);
    end
    set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00); tick();
    checks++;
    if (dout_a[3] !== 16'h0000 || vld_a[3] !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got %h/%b, want 0000/1", dout_a[3], vld_a[3]);
    end
    for (int a = 0; a < 6; a++) begin
      set_op(1'b1, 1'b0, 3'(a), 16'h0, 2'b00); tick();
      set_op(1'b0, 1'b0, 3'd0,  16'h0, 2'b00); tick();
      checks++;
      if (dout_a[3] !== want[a] || vld_a[3] !== 1'b1) begin
        errors++;
        $display("FAIL oor_neighbour[%0d]: got %h/%b, want %h/1", a, dout_a[3], vld_a[3], want[a]);
      end
    end
  endtask

`ifdef OPMEM_PARITY_EN
  task automatic test_parity();
    g_dut[0].u_dut.par_q[4][0] = ~g_dut[0].u_dut.par_q[4][0];
    set_op(1'b1, 1'b0, 3'd4, 16'h0, 2'b00); tick();
    checks++;
    if (perr_a[0] !== 1'b1 || vld_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_flip: got perr=%b vld=%b, want 1/1", perr_a[0], vld_a[0]);
    end
    set_op(1'b1, 1'b0, 3'd5, 16'h0, 2'b00); tick();
    checks++;
    if (perr_a[0] !== 1'b0 || vld_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_clean: got perr=%b vld=%b, want 0/1", perr_a[0], vld_a[0]);
    end
    g_dut[0].u_dut.par_q[4][0] = ~g_dut[0].u_dut.par_q[4][0];
    set_op(1'b0, 1'b0, 3'd0, 16'h0, 2'b00); tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ce  = ($urandom_range(0, 3) != 0);
      oce = ($urandom_range(0, 3) != 0);
      wre = $urandom_range(0, 1) == 1;
      be  = 2'($urandom_range(0, 3));
      ad  = 3'($urandom_range(0, 7));
      din = 16'($urandom);
      tick();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (dout_a[d] !== out_w[d] || vld_a[d] !== out_v[d] || perr_a[d] !== 1'b0) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got %h/%b/%b, want %h/%b/0",
                   d, n, dout_a[d], vld_a[d], perr_a[d], out_w[d], out_v[d]);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_byte_enables();
    test_write_modes();
    test_read_pipeline();
    test_out_of_range();
`ifdef OPMEM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
